datain_buf: RTL and testbench

Ejection-side capture buffer for the NoC functional test set. It is the receiving end of the streaming injection buffers. It samples 20-bit flits presented with a valid strobe at a router's local output port and stores them in order in an internal RAM. It detects end-of-burst by an idle timeout and keeps a running XOR checksum. Stored flits are read back through a registered sequential read port for scoreboarding or debug.

---
 rtl/datain_buf.sv | 156 +++++++++++++++
 tb/tb_datain_buf.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/datain_buf.sv
// datain_buf: ejection-side capture buffer. Stores valid flits in order,
// detects end of burst by idle timeout, keeps a running XOR checksum and
// offers a registered sequential read port.
module datain_buf #(
  parameter int DEPTH        = 30,
  parameter int AW           = 5,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [19:0]   datain,
  input  logic          in_valid,
  input  logic          clear,
  input  logic          rd_en,
  output logic [19:0]   rd_data,
  output logic          rd_valid,
  output logic [AW:0]   count,
  output logic          full,
  output logic          dropped,
  output logic          done,
  output logic [19:0]   checksum
);

  // state   | meaning
  // S_IDLE  | armed, nothing stored yet
  // S_CAPTURE | burst in progress, counting idle cycles since last flit
  // S_DONE  | idle timeout reached; new flits are discarded until clear/rst
  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  localparam int            IW      = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [IW-1:0] TMO_M1  = IW'(IDLE_TIMEOUT - 1);

  logic [19:0]   mem_q [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          dropped_q, dropped_d;
  logic          done_q, done_d;
  logic [19:0]   checksum_q, checksum_d;
  logic [19:0]   rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          wr_en;

  assign full     = (count_q == DEPTH_C);
  assign count    = count_q;
  assign dropped  = dropped_q;
  assign done     = done_q;
  assign checksum = checksum_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  // Next-state logic: clear dominates; capture and read proceed independently.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    idle_cnt_d = idle_cnt_q;
    dropped_d  = dropped_q;
    done_d     = done_q;
    checksum_d = checksum_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wr_en      = 1'b0;
    if (clear) begin
      state_d    = S_IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      idle_cnt_d = '0;
      dropped_d  = 1'b0;
      done_d     = 1'b0;
      checksum_d = '0;
      rd_data_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            wr_en      = 1'b1;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            count_d    = (AW+1)'(1);
            checksum_d = datain;
            idle_cnt_d = '0;
            state_d    = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (in_valid) begin
            idle_cnt_d = '0;
            if (!full) begin
              wr_en      = 1'b1;
              wr_ptr_d   = wr_ptr_q + 1'b1;
              count_d    = count_q + 1'b1;
              checksum_d = checksum_q ^ datain;
            end else begin
              dropped_d = 1'b1;
            end
          end else if (idle_cnt_q == TMO_M1) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
            done_d     = 1'b1;
            state_d    = S_DONE;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (in_valid) dropped_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
      // Pre-edge count is used, so an entry written this edge is not yet readable.
      if (rd_en && (rd_ptr_q < count_q)) begin
        rd_data_d  = mem_q[rd_ptr_q[AW-1:0]];
        rd_valid_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + 1'b1;
      end
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      idle_cnt_q <= '0;
      dropped_q  <= 1'b0;
      done_q     <= 1'b0;
      checksum_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      idle_cnt_q <= idle_cnt_d;
      dropped_q  <= dropped_d;
      done_q     <= done_d;
      checksum_q <= checksum_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Flit storage; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_ptr_q] <= datain;
  end

endmodule

// File: tb/tb_datain_buf.sv
// Self-checking bench for datain_buf: table-driven burst capture plus
// hand-written corner sequences; read data checked against a scoreboard queue.
module tb_datain_buf;

  localparam int DEPTH = 30;
  localparam int AW    = 5;
  localparam int TMO   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [19:0]   datain = '0;
  logic          in_valid = 1'b0;
  logic          clear = 1'b0;
  logic          rd_en = 1'b0;
  logic [19:0]   rd_data;
  logic          rd_valid;
  logic [AW:0]   count;
  logic          full;
  logic          dropped;
  logic          done;
  logic [19:0]   checksum;

  int checks = 0;
  int errors = 0;
  logic [19:0] sb[$];

  typedef struct {
    logic [19:0] data;
    int          exp_count;
    logic [19:0] exp_chk;
  } vec_t;
  vec_t vecs[8];

  datain_buf #(.DEPTH(DEPTH), .AW(AW), .IDLE_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .datain(datain), .in_valid(in_valid),
    .clear(clear), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .full(full), .dropped(dropped), .done(done),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    sb.delete();
  endtask

  // Read-data scoreboard: every rd_valid cycle must match the oldest stored flit.
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got %05h expected no read", rd_data);
      end else begin
        chk("rd_data_sb", 32'(rd_data), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    logic [19:0] model_chk;

    vecs[0] = '{20'h00000, 1, 20'h00000};
    vecs[1] = '{20'h20010, 2, 20'h20010};
    vecs[2] = '{20'h20020, 3, 20'h00030};
    vecs[3] = '{20'h21011, 4, 20'h21021};
    vecs[4] = '{20'h21021, 5, 20'h00000};
    vecs[5] = '{20'h23013, 6, 20'h23013};
    vecs[6] = '{20'h23023, 7, 20'h00030};
    vecs[7] = '{20'h22422, 8, 20'h22412};

    // Reset state
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // 1: back-to-back burst, then idle timeout
    for (int i = 0; i < 8; i++) begin
      datain = vecs[i].data;
      in_valid = 1'b1;
      tick();
      sb.push_back(vecs[i].data);
      chk("s1_count", 32'(count), 32'(vecs[i].exp_count));
      chk("s1_checksum", 32'(checksum), 32'(vecs[i].exp_chk));
    end
    in_valid = 1'b0;
    for (int j = 1; j <= TMO; j++) begin
      tick();
      chk("s1_done_timing", 32'(done), 32'(j == TMO));
    end
    chk("s1_full", 32'(full), 0);
    chk("s1_dropped", 32'(dropped), 0);

    // 2: read back all entries with rd_en held for 10 cycles
    rd_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("s2_rd_valid", 32'(rd_valid), 32'(i <= 8));
    end
    rd_en = 1'b0;
    tick();
    chk("s2_rd_valid_off", 32'(rd_valid), 0);
    chk("s2_rd_data_hold", 32'(rd_data), 32'h22422);
    chk("s2_sb_empty", 32'(sb.size()), 0);

    // 3: 7-cycle gaps keep the burst alive; an 8-cycle gap ends it
    do_clear();
    chk("s3_clear_done", 32'(done), 0);
    for (int k = 0; k < 3; k++) begin
      datain = 20'h00100 + 20'(k);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int j = 1; j <= ((k < 2) ? 7 : 8); j++) begin
        tick();
        chk("s3_done_gap", 32'(done), 32'(j == 8));
      end
    end
    datain = 20'h00999;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("s3_dropped", 32'(dropped), 1);
    chk("s3_count", 32'(count), 3);

    // 4: overfill by one flit
    do_clear();
    model_chk = '0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      datain = 20'(i + 1);
      in_valid = 1'b1;
      tick();
      if (i < DEPTH) begin
        sb.push_back(20'(i + 1));
        model_chk ^= 20'(i + 1);
      end
      if (i == DEPTH - 1) begin
        chk("s4_full_at_depth", 32'(full), 1);
        chk("s4_no_drop_yet", 32'(dropped), 0);
      end
    end
    in_valid = 1'b0;
    chk("s4_count", 32'(count), 32'(DEPTH));
    chk("s4_full", 32'(full), 1);
    chk("s4_dropped", 32'(dropped), 1);
    chk("s4_checksum", 32'(checksum), 32'(model_chk));
    rd_en = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      tick();
      chk("s4_rd_valid", 32'(rd_valid), 32'(i < DEPTH));
    end
    rd_en = 1'b0;
    chk("s4_last_entry", 32'(rd_data), 32'h0001E);
    chk("s4_sb_empty", 32'(sb.size()), 0);

    // 5: clear coincident with a valid flit, then write/read collision
    do_clear();
    for (int i = 0; i < 5; i++) begin
      datain = 20'h00A00 + 20'(i);
      in_valid = 1'b1;
      tick();
    end
    datain = 20'hABCDE;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    chk("s5_count", 32'(count), 0);
    chk("s5_dropped", 32'(dropped), 0);
    chk("s5_checksum", 32'(checksum), 0);
    datain = 20'h12345;
    in_valid = 1'b1;
    rd_en = 1'b1;
    tick();
    sb.push_back(20'h12345);
    in_valid = 1'b0;
    chk("s5_collide_no_read", 32'(rd_valid), 0);
    chk("s5_count1", 32'(count), 1);
    chk("s5_checksum1", 32'(checksum), 32'h12345);
    tick();
    rd_en = 1'b0;
    chk("s5_read_next", 32'(rd_valid), 1);
    chk("s5_rd_data", 32'(rd_data), 32'h12345);

    // 6: asynchronous reset between edges mid-stream
    for (int i = 0; i < 3; i++) begin
      datain = 20'h05550 + 20'(i);
      in_valid = 1'b1;
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    chk("s6_count", 32'(count), 0);
    chk("s6_checksum", 32'(checksum), 0);
    chk("s6_rd_data", 32'(rd_data), 0);
    chk("s6_outs", 32'({full, dropped, done, rd_valid}), 0);
    in_valid = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    tick();
    datain = 20'hABCDE;
    in_valid = 1'b1;
    tick();
    sb.push_back(20'hABCDE);
    in_valid = 1'b0;
    chk("s6_count1", 32'(count), 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("s6_rd_valid", 32'(rd_valid), 1);
    tick();
    chk("s6_sb_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
